// File: rtl/sti_pkg.sv
// rtl/sti_pkg.sv - shared types and helpers for the STI load sequencer
// Descriptor layout and serializer length codes.
package sti_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_START,
    S_SHIFT,
    S_GAP,
    S_END,
    S_DONE,
    S_ERR
  } seq_state_t;

  localparam logic [1:0] LEN_8  = 2'b00;
  localparam logic [1:0] LEN_16 = 2'b01;
  localparam logic [1:0] LEN_24 = 2'b10;
  localparam logic [1:0] LEN_32 = 2'b11;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  length;
    logic        fill;
    logic        msb;
    logic        low;
    logic        last;
  } sti_desc_t;

  // 8 * (length + 1): the length code times eight, plus one byte
  function automatic logic [5:0] len_bits(input logic [1:0] length);
    return {1'b0, length, 3'b000} + 6'd8;
  endfunction

endpackage

// File: rtl/sti_cmd_fifo.sv
// rtl/sti_cmd_fifo.sv - descriptor FIFO feeding the load sequencer
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module sti_cmd_fifo
  import sti_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  logic      i_push,
  input  sti_desc_t i_wdata,
  input  logic      i_pop,
  output sti_desc_t o_rdata,
  output logic      o_full,
  output logic      o_empty
);
  localparam int AW = $clog2(DEPTH);

  sti_desc_t   r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/sti_load_sequencer.sv
// rtl/sti_load_sequencer.sv - sequencer driving parallel words into the STI serializer
// Loads one buffered descriptor per word and counts so_valid bits to pace the next load.
module sti_load_sequencer
  import sti_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int GAP_CYCLES    = 1,
  parameter int START_TIMEOUT = 64
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [15:0] i_cmd_data,
  input  logic [1:0]  i_cmd_length,
  input  logic        i_cmd_fill,
  input  logic        i_cmd_msb,
  input  logic        i_cmd_low,
  input  logic        i_cmd_last,
  input  logic        i_so_valid,
  input  logic        i_oem_finish,
  output logic        o_load,
  output logic [15:0] o_pi_data,
  output logic [1:0]  o_pi_length,
  output logic        o_pi_fill,
  output logic        o_pi_msb,
  output logic        o_pi_low,
  output logic        o_pi_end,
  output logic        o_busy,
  output logic [7:0]  o_words_sent,
  output logic        o_done,
  output logic        o_err
);
  localparam int              TW       = $clog2(START_TIMEOUT) + 1;
  localparam logic [TW-1:0]   TMO_LAST = TW'(START_TIMEOUT - 1);
  localparam logic [3:0]      GAP_LAST = 4'(GAP_CYCLES - 1);

  seq_state_t    r_state;
  logic          r_load, r_pi_end, r_busy, r_done, r_err;
  logic [15:0]   r_pi_data;
  logic [1:0]    r_pi_length;
  logic          r_pi_fill, r_pi_msb, r_pi_low;
  logic [7:0]    r_words;
  logic [5:0]    r_nbits, r_bits;
  logic          r_last, r_last_seen;
  logic [TW-1:0] r_tmo;
  logic [3:0]    r_gap;

  sti_desc_t w_cmd, w_head;
  logic      w_push, w_pop, w_full, w_empty;

  assign w_cmd       = {i_cmd_data, i_cmd_length, i_cmd_fill, i_cmd_msb, i_cmd_low, i_cmd_last};
  assign o_cmd_ready = !w_full && !r_last_seen;
  assign w_push      = i_cmd_valid && o_cmd_ready;
  assign w_pop       = (r_state == S_LOAD);

  sti_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_reset_n),
    .i_push  (w_push),
    .i_wdata (w_cmd),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_load      <= 1'b0;
      r_pi_data   <= '0;
      r_pi_length <= '0;
      r_pi_fill   <= 1'b0;
      r_pi_msb    <= 1'b0;
      r_pi_low    <= 1'b0;
      r_pi_end    <= 1'b0;
      r_busy      <= 1'b0;
      r_words     <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_nbits     <= '0;
      r_bits      <= '0;
      r_last      <= 1'b0;
      r_last_seen <= 1'b0;
      r_tmo       <= '0;
      r_gap       <= '0;
    end else begin
      r_load <= 1'b0;
      if (w_push && i_cmd_last) r_last_seen <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_state     <= S_LOAD;
            r_load      <= 1'b1;
            r_busy      <= 1'b1;
            r_pi_data   <= w_head.data;
            r_pi_length <= w_head.length;
            r_pi_fill   <= w_head.fill;
            r_pi_msb    <= w_head.msb;
            r_pi_low    <= w_head.low;
          end
        end
        S_LOAD: begin
          r_nbits <= len_bits(w_head.length);
          r_last  <= w_head.last;
          r_bits  <= '0;
          r_tmo   <= '0;
          r_state <= S_WAIT_START;
        end
        S_WAIT_START: begin
          if (i_so_valid) begin
            r_bits  <= 6'd1;
            r_state <= S_SHIFT;
          end else if (r_tmo == TMO_LAST) begin
            r_state <= S_ERR;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_SHIFT: begin
          // so_valid may have holes; only strobed cycles advance the count
          if (i_so_valid) begin
            if (r_bits + 6'd1 == r_nbits) begin
              r_words <= r_words + 8'd1;
              r_gap   <= '0;
              r_state <= S_GAP;
            end else begin
              r_bits <= r_bits + 6'd1;
            end
          end
        end
        S_GAP: begin
          if (r_gap == GAP_LAST) begin
            if (r_last) begin
              r_state  <= S_END;
              r_pi_end <= 1'b1;
            end else if (!w_empty) begin
              r_state     <= S_LOAD;
              r_load      <= 1'b1;
              r_pi_data   <= w_head.data;
              r_pi_length <= w_head.length;
              r_pi_fill   <= w_head.fill;
              r_pi_msb    <= w_head.msb;
              r_pi_low    <= w_head.low;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_gap <= r_gap + 4'd1;
          end
        end
        S_END: begin
          if (i_oem_finish) begin
            r_state  <= S_DONE;
            r_pi_end <= 1'b0;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
          end
        end
        S_DONE, S_ERR: ;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_load       = r_load;
  assign o_pi_data    = r_pi_data;
  assign o_pi_length  = r_pi_length;
  assign o_pi_fill    = r_pi_fill;
  assign o_pi_msb     = r_pi_msb;
  assign o_pi_low     = r_pi_low;
  assign o_pi_end     = r_pi_end;
  assign o_busy       = r_busy;
  assign o_words_sent = r_words;
  assign o_done       = r_done;
  assign o_err        = r_err;

endmodule
